// File: rtl/degamma_lut_pkg.sv
// Shared definitions for the degamma LUT stage: write-select codes,
// RGB field-slice offsets and the fill/run state encoding.
package degamma_lut_pkg;

    // wr_sel codes; R/G/B also serve as the channel index of each table
    localparam logic [1:0] CH_R   = 2'd0;
    localparam logic [1:0] CH_G   = 2'd1;
    localparam logic [1:0] CH_B   = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    // Table controller states
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // LSB of a channel inside the packed {R,G,B} word: R on top, B at bit 0
    function automatic int ch_lsb(input int ch, input int dw);
        return (2 - ch) * dw;
    endfunction

endpackage

// File: rtl/degamma_ram.sv
// One channel table: 2^DW x DW simple dual-port RAM with a registered
// read. A read and write to the same address in one cycle return the old
// entry; the new value is visible from the following cycle.
module degamma_ram #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [DW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<DW)-1];
    logic [DW-1:0] rdata_q;

    // Single write port, shared by the identity fill and the host
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Synchronous read; sees the pre-write contents on a collision
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/degamma_lut.sv
// Inverse-gamma stage: each 8-bit channel of the RGB stream is looked up
// in its own host-programmable table. Tables self-fill with identity after
// reset; until then, and whenever degamma_en is low, pixels bypass the
// tables with the same 2-cycle latency.
module degamma_lut
    import degamma_lut_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          degamma_en,
    input  logic [3*DW-1:0] pre_rgb_data,
    input  logic          pre_rgb_en,
    output logic [3*DW-1:0] post_rgb_data,
    output logic          post_rgb_en,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [DW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          init_done
);

    // Pixel-path latency; the valid chain below is this long
    localparam int LAT = 2;

    state_e          state_q;
    logic [DW-1:0]   cnt_q;

    logic [2:0]      ram_we;
    logic [DW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   rd_ch [3];
    logic [3*DW-1:0] lut_rgb;

    logic [LAT-1:0]  vld_sr_q;
    logic [3*DW-1:0] pix_p1_q;
    logic            byp_p1_q;
    logic            byp_d;
    logic [3*DW-1:0] post_p2_q;

    // Fill controller: writes entry[cnt]=cnt for every index, then parks in RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign wr_ready  = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);

    // Table write mux: the fill owns all three ports during INIT, and host
    // strobes arriving then are simply dropped
    always_comb begin
        ram_we    = '0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (state_q == ST_INIT) begin
            ram_we    = 3'b111;
            ram_waddr = cnt_q;
            ram_wdata = cnt_q;
        end else if (wr_en) begin
            ram_we[0] = (wr_sel == CH_R) || (wr_sel == CH_ALL);
            ram_we[1] = (wr_sel == CH_G) || (wr_sel == CH_ALL);
            ram_we[2] = (wr_sel == CH_B) || (wr_sel == CH_ALL);
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_tbl
        degamma_ram #(
            .DW (DW)
        ) u_ram (
            .clk     (clk),
            .we_i    (ram_we[ch]),
            .waddr_i (ram_waddr),
            .wdata_i (ram_wdata),
            .raddr_i (pre_rgb_data[ch_lsb(ch, DW) +: DW]),
            .rdata_o (rd_ch[ch])
        );
    end

    assign lut_rgb = {rd_ch[0], rd_ch[1], rd_ch[2]};
    assign byp_d   = !degamma_en || (state_q != ST_RUN);

    // ---- Stage 1: capture pixel and bypass decision; table reads issued ----

    // Valid chain; only control is reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= {vld_sr_q[LAT-2:0], pre_rgb_en};
        end
    end

    // Stage-1 data and bypass flag, meaningful only alongside a valid
    always_ff @(posedge clk) begin
        pix_p1_q <= pre_rgb_data;
        byp_p1_q <= byp_d;
    end

    // ---- Stage 2: select table result or raw pixel; hold when idle ----

    // Output register updates only for valid pixels, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_p2_q <= '0;
        end else if (vld_sr_q[0]) begin
            post_p2_q <= byp_p1_q ? pix_p1_q : lut_rgb;
        end
    end

    assign post_rgb_data = post_p2_q;
    assign post_rgb_en   = vld_sr_q[LAT-1];

endmodule

// File: tb/tb_degamma_lut.sv
// Directed bench for degamma_lut: identity fill timing, host writes,
// bypass, collision ordering, INIT pass-through and mid-fill reset.
module tb_degamma_lut;
    import degamma_lut_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          degamma_en;
    logic [23:0]   pre_rgb_data;
    logic          pre_rgb_en;
    logic [23:0]   post_rgb_data;
    logic          post_rgb_en;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [7:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          init_done;

    int n_chk  = 0;
    int n_pass = 0;

    degamma_lut #(.DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .degamma_en    (degamma_en),
        .pre_rgb_data  (pre_rgb_data),
        .pre_rgb_en    (pre_rgb_en),
        .post_rgb_data (post_rgb_data),
        .post_rgb_en   (post_rgb_en),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One pixel in; returns the output word two edges later
    task automatic run_pix(input logic [23:0] d, input logic deg, output logic [23:0] q);
        @(negedge clk);
        pre_rgb_data = d;
        pre_rgb_en   = 1'b1;
        degamma_en   = deg;
        @(posedge clk);
        #1 pre_rgb_en = 1'b0;
        @(posedge clk);
        #1 q = post_rgb_data;
    endtask

    task automatic host_wr(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Releases reset and checks the 256-edge fill window
    task automatic release_and_fill(input string tag);
        logic early;
        early = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (255) begin
            @(posedge clk);
            #1 if (init_done || wr_ready) early = 1'b1;
        end
        chk({tag, "_low_255"}, {23'd0, early}, 24'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_256"}, {23'd0, init_done}, 24'd1);
        chk({tag, "_ready_256"}, {23'd0, wr_ready}, 24'd1);
    endtask

    logic [23:0] q;
    logic [23:0] obs_d [6];
    logic        obs_v [6];

    initial begin
        rst_n        = 1'b0;
        degamma_en   = 1'b1;
        pre_rgb_data = '0;
        pre_rgb_en   = 1'b0;
        wr_en        = 1'b0;
        wr_sel       = CH_R;
        wr_addr      = '0;
        wr_data      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_post_en", {23'd0, post_rgb_en}, 24'd0);
        chk("rst_post_data", post_rgb_data, 24'd0);
        chk("rst_init_done", {23'd0, init_done}, 24'd0);
        chk("rst_wr_ready", {23'd0, wr_ready}, 24'd0);

        release_and_fill("fill1");

        // Identity after fill
        run_pix(24'h102030, 1'b1, q);
        chk("identity", q, 24'h102030);
        chk("post_en_pulse", {23'd0, post_rgb_en}, 24'd1);

        // Per-channel host writes
        host_wr(CH_R, 8'h10, 8'hAA);
        host_wr(CH_G, 8'h20, 8'h55);
        run_pix(24'h102030, 1'b1, q);
        chk("lut_rg", q, 24'hAA5530);
        run_pix(24'h102030, 1'b0, q);
        chk("bypass_en0", q, 24'h102030);

        // Broadcast write to all tables
        host_wr(CH_ALL, 8'hFF, 8'h00);
        run_pix(24'hFFFFFF, 1'b1, q);
        chk("all_ff", q, 24'h000000);
        run_pix(24'hFEFEFE, 1'b1, q);
        chk("all_fe", q, 24'hFEFEFE);

        // Same-cycle write/read on R addr 0x40: old value, then new
        @(negedge clk);
        wr_en = 1'b1; wr_sel = CH_R; wr_addr = 8'h40; wr_data = 8'h99;
        pre_rgb_data = 24'h404040; pre_rgb_en = 1'b1; degamma_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1 chk("coll_old", post_rgb_data, 24'h404040);
        pre_rgb_en = 1'b0;
        @(posedge clk);
        #1 chk("coll_new", post_rgb_data, 24'h994040);

        // Reset again; valid pattern 1,0,1,1 during INIT passes straight through
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pre_rgb_data = 24'(k + 1);
            pre_rgb_en   = (k == 0 || k == 2 || k == 3);
            @(posedge clk);
            #1;
            obs_d[k] = post_rgb_data;
            obs_v[k] = post_rgb_en;
        end
        pre_rgb_en = 1'b0;
        chk("init_v1", {23'd0, obs_v[1]}, 24'd1);
        chk("init_d1", obs_d[1], 24'd1);
        chk("init_v2", {23'd0, obs_v[2]}, 24'd0);
        chk("init_d2_hold", obs_d[2], 24'd1);
        chk("init_v3", {23'd0, obs_v[3]}, 24'd1);
        chk("init_d3", obs_d[3], 24'd3);
        chk("init_v4", {23'd0, obs_v[4]}, 24'd1);
        chk("init_d4", obs_d[4], 24'd4);
        chk("init_v5", {23'd0, obs_v[5]}, 24'd0);

        // Host write late in INIT, to an index the fill has already passed
        repeat (190) @(posedge clk);
        host_wr(CH_ALL, 8'h05, 8'h77);

        begin
            int guard;
            guard = 0;
            while (!init_done && guard < 300) begin
                @(posedge clk);
                #1 guard++;
            end
            chk("init2_timeout", {23'd0, init_done}, 24'd1);
        end
        run_pix(24'h050505, 1'b1, q);
        chk("init_wr_dropped", q, 24'h050505);
        run_pix(24'h102030, 1'b1, q);
        chk("refill_rg", q, 24'h102030);
        run_pix(24'h40FFFF, 1'b1, q);
        chk("refill_ff40", q, 24'h40FFFF);

        // Load non-identity entries, then reset mid-fill at count 100
        host_wr(CH_R, 8'h10, 8'hAA);
        host_wr(CH_ALL, 8'h80, 8'h01);
        run_pix(24'h108000, 1'b1, q);
        chk("pre_reset_lut", q, 24'hAA0100);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pre_rgb_data = 24'h123456;
        pre_rgb_en   = 1'b1;
        repeat (100) @(posedge clk);
        #1 chk("midfill_bypass", post_rgb_data, 24'h123456);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_post_en", {23'd0, post_rgb_en}, 24'd0);
        chk("midrst_post_data", post_rgb_data, 24'd0);
        chk("midrst_init_done", {23'd0, init_done}, 24'd0);
        pre_rgb_en = 1'b0;
        release_and_fill("fill3");
        run_pix(24'h108000, 1'b1, q);
        chk("post_reset_identity", q, 24'h108000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/degamma_lut.md
Name: degamma_lut

Overview:
- Inverse-gamma (linearisation) stage for the 24-bit RGB pixel stream.
- Maps each 8-bit channel through its own 256-entry table. The tables are programmable by a host write port, so any curve that undoes the display gamma can be loaded.
- After reset the tables fill themselves with identity. Pixel path is a fixed 2-cycle pipeline with valid alignment.
- Sits ahead of the gamma stage in the ISP chain, or on the return path when linear-light processing is needed.

Parameters:
- DW, 8, bits per colour channel; each table depth is 2^DW.
- LAT, 2, pixel-path latency in cycles; fixed and not user-overridable (documents the pipeline).

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  synchronous active-low reset
- degamma_en  input  1  1 = apply tables, 0 = bypass; sampled per pixel in stage 1
- pre_rgb_data  input  3*DW  {R,G,B} input pixel
- pre_rgb_en  input  1  input pixel valid
- post_rgb_data  output  3*DW  {R,G,B} output pixel
- post_rgb_en  output  1  output pixel valid
- wr_en  input  1  host table write strobe
- wr_sel  input  2  0=R, 1=G, 2=B, 3=all three tables
- wr_addr  input  DW  table index
- wr_data  input  DW  table entry
- wr_ready  output  1  1 when host writes are accepted
- init_done  output  1  1 once identity fill has completed

Behaviour:
- Reset is synchronous: rst_n low at a clk edge sets state=INIT, fill counter=0, both pipeline valids=0, post_rgb_data=0, post_rgb_en=0, wr_ready=0, init_done=0.
- Table contents are not cleared by reset; they are rewritten by INIT.
- FSM, two states:
  - INIT: each cycle, write entry[cnt]=cnt into all three tables and increment cnt. After writing cnt=2^DW-1, go to RUN; this takes 2^DW cycles, 256 by default.
  - RUN: terminal; left only by reset.
  - Reset asserted during INIT restarts the fill from 0.
- init_done and wr_ready are 1 exactly when state=RUN.
- Host writes:
  - Accepted only when wr_en=1 and wr_ready=1.
  - The write lands in the table(s) at the clock edge.
  - wr_en during INIT is ignored and dropped; it is not queued.
  - wr_sel=3 writes the same wr_data at wr_addr in all three tables.
- Pixel pipeline:
  - Stage 1 registers pre_rgb_data, pre_rgb_en, and a bypass flag = (!degamma_en || state!=RUN). Stage 1 also issues the three table reads.
  - Stage 2 registers either the table outputs, or the stage-1 data when the bypass flag is set.
  - post_rgb_en is pre_rgb_en delayed exactly 2 cycles.
  - post_rgb_data updates only when the stage-2 valid is 1, and holds its last value otherwise.
  - Pixels entering during INIT therefore pass through unchanged with the same 2-cycle latency.
- Read/write collision: a host write and a pixel read hitting the same table address in the same cycle return the OLD entry (read-before-write). The new value is seen from the next cycle.
- Arithmetic: none; the tables are pure lookup. Channel ordering is R=[3*DW-1:2*DW], G=[2*DW-1:DW], B=[DW-1:0].
- No backpressure: the block accepts a pixel every cycle.
- Table memory: one simple dual-port RAM per channel, with a synchronous read and a single write port. The write port is muxed between the INIT fill and the host.

Decomposition:
- Shared ISP package holds:
  - constants CH_R=0, CH_G=1, CH_B=2, CH_ALL=3 for wr_sel;
  - the RGB field-slice offsets;
  - the FSM state encoding localparams (ST_INIT, ST_RUN).
- One natural sub-module: degamma_ram, a 2^DW x DW synchronous-read, read-before-write dual-port RAM, instantiated three times.
- FSM, write mux and pipeline stay in the top.

Test Plan:
- Reset, then hold rst_n=1 -> init_done=0 for 256 cycles after reset release and 1 on the 257th. Stream 0x102030 with degamma_en=1 after that -> output 0x102030 two cycles later (identity).
- After init, write R table addr 0x10 = 0xAA and G addr 0x20 = 0x55 -> input 0x102030 yields 0xAA5530 at cycle +2. With degamma_en=0, the same input yields 0x102030.
- wr_sel=3, addr 0xFF, data 0x00 -> input 0xFFFFFF yields 0x000000. Input 0xFEFEFE stays 0xFEFEFE.
- Pixel valid pattern 1,0,1,1 with data values 1..4 during INIT -> post_rgb_en pattern 1,0,1,1 delayed 2 cycles, data bypassed unchanged. A wr_en issued during INIT is dropped: the table still reads identity after init.
- Same-cycle write addr 0x40 = 0x99 and pixel R=0x40 -> output R=0x40 (old). Next pixel R=0x40 -> 0x99.
- Assert rst_n=0 for one cycle at fill count 100 -> outputs cleared next edge, init_done stays 0 for a full 256 more cycles, and previously written entries are identity afterwards.
